spi_frame_master: RTL and testbench

Single-bit-per-clock SPI master that generates command frames for the SPI slave/RAM subsystem, driving `ss_n` and `mosi` and capturing read data from `miso`. It sits on the bench/host side of the SPI link. It accepts one 10-bit command word per transaction:

- Command format: `[9:8]` opcode, `[7:0]` address/data.
- Opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read data.

For read-data frames it keeps the slave selected and shifts in the 8-bit response.

---
 rtl/spi_frame_master.sv | 163 ++++++++++++++++
 tb/tb_spi_frame_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// SPI master for command frames to the SPI slave/RAM link: select, command bit,
// 10-bit word, latch, and for read-data frames an 8-bit capture from miso.
module spi_frame_master #(
    parameter int READ_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] cmd,
    input  logic       miso,
    output logic       ss_n,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       seq_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CMD,
        S_SHIFT,
        S_LATCH,
        S_WAIT,
        S_CAPTURE,
        S_DESELECT
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [9:0] r_cmd;
    logic [9:0] w_cmd_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       r_addr_armed;
    logic       w_ss_n_nxt;
    logic       w_mosi_nxt;
    logic       w_fin;
    logic       w_rd_frame;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_cmd   <= w_cmd_nxt;
        r_shift <= w_shift_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cmd_nxt   = r_cmd;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cmd_nxt   = cmd;
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: w_state_nxt = S_CMD;
            S_CMD: begin
                w_state_nxt = S_SHIFT;
                w_cnt_nxt   = 4'd0;
            end
            S_SHIFT: begin
                if (r_cnt == 4'd9) begin
                    w_state_nxt = S_LATCH;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_LATCH: begin
                w_state_nxt = (r_cmd[9:8] == 2'b11) ? S_WAIT : S_DESELECT;
                w_cnt_nxt   = 4'd0;
            end
            S_WAIT: begin
                if (r_cnt == WAIT_LAST) begin
                    w_state_nxt = S_CAPTURE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_CAPTURE: begin
                // first sampled bit ends up in bit 7 after eight shifts
                w_shift_nxt = {r_shift[6:0], miso};
                if (r_cnt == 4'd7) begin
                    w_state_nxt = S_DESELECT;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DESELECT: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        w_ss_n_nxt = 1'b1;
        w_mosi_nxt = 1'b0;
        case (w_state_nxt)
            S_SELECT, S_CMD: begin
                w_ss_n_nxt = 1'b0;
                w_mosi_nxt = w_cmd_nxt[9];
            end
            S_SHIFT: begin
                w_ss_n_nxt = 1'b0;
                w_mosi_nxt = w_cmd_nxt[4'd9 - w_cnt_nxt];
            end
            S_LATCH, S_WAIT, S_CAPTURE: w_ss_n_nxt = 1'b0;
            default: begin
                w_ss_n_nxt = 1'b1;
                w_mosi_nxt = 1'b0;
            end
        endcase

        w_fin      = (w_state_nxt == S_DESELECT);
        w_rd_frame = (r_cmd[9:8] == 2'b11);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_n         <= 1'b1;
            mosi         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_valid     <= 1'b0;
            seq_err      <= 1'b0;
            rd_data      <= 8'h00;
            r_addr_armed <= 1'b0;
        end else begin
            ss_n     <= w_ss_n_nxt;
            mosi     <= w_mosi_nxt;
            busy     <= (w_state_nxt != S_IDLE);
            done     <= w_fin;
            rd_valid <= w_fin && w_rd_frame;
            // armed only changes at deselect, so here it still reflects the frame start
            seq_err  <= w_fin && w_rd_frame && !r_addr_armed;
            if (w_fin) begin
                r_addr_armed <= (r_cmd[9:8] == 2'b10);
            end
            if (w_fin && w_rd_frame) begin
                rd_data <= w_shift_nxt;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: per-cycle recording of frame outputs
// compared against hand-derived cycle timelines (READ_WAIT = 3).
module tb_spi_frame_master;

    localparam int RW = 3;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] cmd;
    logic       miso;
    logic       ss_n;
    logic       mosi;
    logic       busy;
    logic       done;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       seq_err;

    int n_checks;
    int n_errors;

    logic       rec_ss   [0:31];
    logic       rec_mosi [0:31];
    logic       rec_done [0:31];
    logic       rec_rv   [0:31];
    logic       rec_se   [0:31];
    logic       rec_busy [0:31];
    logic [7:0] rec_rd   [0:31];

    spi_frame_master #(.READ_WAIT(RW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmd     (cmd),
        .miso    (miso),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .busy    (busy),
        .done    (done),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .seq_err (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 into an idle cycle; returns at #1 into cycle ncyc of the frame.
    task automatic run_frame(input logic [9:0] c, input logic [7:0] mb, input int ncyc,
                             input bit disturb);
        start = 1'b1;
        cmd   = c;
        step();
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            rec_ss[k]   = ss_n;
            rec_mosi[k] = mosi;
            rec_done[k] = done;
            rec_rv[k]   = rd_valid;
            rec_se[k]   = seq_err;
            rec_busy[k] = busy;
            rec_rd[k]   = rd_data;
            miso  = (k >= 13 + RW && k <= 20 + RW) ? mb[20 + RW - k] : 1'b0;
            start = disturb && (k == 5 || k == 10);
            if (disturb && k == 3) cmd = ~c;
            step();
        end
        start = 1'b0;
        miso  = 1'b0;
    endtask

    logic [9:0] exp_cmd;
    int         n_done;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        cmd   = 10'h000;
        miso  = 1'b0;

        // Reset held with start asserted
        start = 1'b1;
        cmd   = 10'h3FF;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val($sformatf("rst_ss_%0d", k), ss_n, 1'b1);
            check_val($sformatf("rst_mosi_%0d", k), mosi, 1'b0);
            check_val($sformatf("rst_busy_%0d", k), busy, 1'b0);
            check_val($sformatf("rst_rd_%0d", k), rd_data, 8'h00);
            check_val($sformatf("rst_done_%0d", k), done, 1'b0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        check_val("post_rst_ss", ss_n, 1'b1);
        check_val("post_rst_busy", busy, 1'b0);

        // Write-address frame 00_1010_0101
        exp_cmd = 10'b00_1010_0101;
        run_frame(exp_cmd, 8'h00, 15, 1'b0);
        for (int k = 2; k <= 11; k++)
            check_val($sformatf("wr_mosi_c%0d", k), rec_mosi[k], exp_cmd[11 - k]);
        for (int k = 0; k < 15; k++) begin
            check_val($sformatf("wr_ss_c%0d", k), rec_ss[k], (k <= 12) ? 1'b0 : 1'b1);
            check_val($sformatf("wr_done_c%0d", k), rec_done[k], (k == 13) ? 1'b1 : 1'b0);
            check_val($sformatf("wr_busy_c%0d", k), rec_busy[k], (k <= 13) ? 1'b1 : 1'b0);
        end
        check_val("wr_rv", rec_rv[13], 1'b0);
        check_val("wr_se", rec_se[13], 1'b0);

        // Read-address then read-data, slave returns C3
        run_frame(10'b10_0000_0011, 8'h00, 15, 1'b0);
        check_val("ra_done", rec_done[13], 1'b1);
        check_val("ra_se", rec_se[13], 1'b0);
        exp_cmd = 10'b11_0000_0000;
        run_frame(exp_cmd, 8'hC3, 26, 1'b0);
        check_val("rd_mosi_c0", rec_mosi[0], 1'b1);
        check_val("rd_mosi_c1", rec_mosi[1], 1'b1);
        for (int k = 2; k <= 11; k++)
            check_val($sformatf("rd_mosi_c%0d", k), rec_mosi[k], exp_cmd[11 - k]);
        for (int k = 0; k < 26; k++) begin
            check_val($sformatf("rd_ss_c%0d", k), rec_ss[k], (k <= 23) ? 1'b0 : 1'b1);
            check_val($sformatf("rd_done_c%0d", k), rec_done[k], (k == 24) ? 1'b1 : 1'b0);
            check_val($sformatf("rd_rv_c%0d", k), rec_rv[k], (k == 24) ? 1'b1 : 1'b0);
            check_val($sformatf("rd_se_c%0d", k), rec_se[k], 1'b0);
        end
        for (int k = 12; k <= 23; k++)
            check_val($sformatf("rd_mosi0_c%0d", k), rec_mosi[k], 1'b0);
        check_val("rd_data_c23", rec_rd[23], 8'h00);
        check_val("rd_data_c24", rec_rd[24], 8'hC3);
        check_val("rd_busy_c24", rec_busy[24], 1'b1);
        check_val("rd_busy_c25", rec_busy[25], 1'b0);
        check_val("rd_data_hold", rd_data, 8'hC3);

        // Read-data directly after a write frame flags a sequence error
        run_frame(10'b00_0000_0001, 8'h00, 15, 1'b0);
        run_frame(10'b11_0000_0000, 8'h5A, 26, 1'b0);
        check_val("se_done", rec_done[24], 1'b1);
        check_val("se_flag", rec_se[24], 1'b1);
        check_val("se_rv", rec_rv[24], 1'b1);
        check_val("se_flag_c25", rec_se[25], 1'b0);
        check_val("se_data", rd_data, 8'h5A);

        // start pulses and cmd change during an active frame
        exp_cmd = 10'b01_1100_1010;
        run_frame(exp_cmd, 8'h00, 30, 1'b1);
        for (int k = 2; k <= 11; k++)
            check_val($sformatf("ign_mosi_c%0d", k), rec_mosi[k], exp_cmd[11 - k]);
        n_done = 0;
        for (int k = 0; k < 30; k++) n_done += int'(rec_done[k]);
        check_val("ign_done_count", n_done, 1);
        for (int k = 13; k < 30; k++)
            check_val($sformatf("ign_ss_c%0d", k), rec_ss[k], 1'b1);

        // Arm, then reset in cycle 7 of a read-data frame
        run_frame(10'b10_0000_0000, 8'h00, 15, 1'b0);
        start = 1'b1;
        cmd   = 10'b11_0000_0000;
        step();
        start = 1'b0;
        repeat (7) step();
        check_val("abort_ss_c7", ss_n, 1'b0);
        rst_n = 1'b0;
        step();
        check_val("abort_ss", ss_n, 1'b1);
        check_val("abort_mosi", mosi, 1'b0);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_rd", rd_data, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val($sformatf("abort_done_%0d", k), done, 1'b0);
            check_val($sformatf("abort_rv_%0d", k), rd_valid, 1'b0);
        end
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n_done += int'(done);
        end
        check_val("abort_no_done", n_done, 0);

        // armed flag must have been cleared by the reset
        run_frame(10'b11_0000_0000, 8'h81, 26, 1'b0);
        check_val("post_abort_se", rec_se[24], 1'b1);
        check_val("post_abort_rv", rec_rv[24], 1'b1);
        check_val("post_abort_data", rd_data, 8'h81);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
